// File: rtl/exp_pkg.sv
// Shared types and constants for the iterative e^x unit.
// Holds the state enum and the inverse-factorial coefficient generator.
package exp_pkg;

    localparam int EXP_FRAC_W    = 16;
    localparam int EXP_RES_W     = EXP_FRAC_W + 2;
    localparam int EXP_MAX_TERMS = 12;
    localparam int EXP_K_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } exp_state_e;

    // round(2^fw / k!) computed as (2^(fw+1)/k! + 1) >> 1
    function automatic logic [63:0] inv_fact_q(input int k, input int fw);
        logic [63:0] fact;
        logic [63:0] num;
        fact = 64'd1;
        for (int i = 2; i <= k; i++) begin
            fact = fact * 64'(i);
        end
        num = 64'd1 << (fw + 1);
        return ((num / fact) + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/exp_coeff_rom.sv
// Combinational coefficient table: index k -> c_k = 1/k! in unsigned Q2.FRAC_W.
// Entries beyond the supported series length read as zero.
module exp_coeff_rom
    import exp_pkg::*;
#(
    parameter int FRAC_W = EXP_FRAC_W
)
(
    input  logic [EXP_K_W-1:0] k_i,
    output logic [FRAC_W+1:0]  coeff_o
);

    localparam int RES_W = FRAC_W + 2;
    localparam int DEPTH = 2 ** EXP_K_W;

    logic [RES_W-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        if (g < EXP_MAX_TERMS) begin : g_used
            assign rom[g] = RES_W'(inv_fact_q(g, FRAC_W));
        end else begin : g_pad
            assign rom[g] = '0;
        end
    end

    assign coeff_o = rom[k_i];

endmodule

// File: rtl/exponential.sv
// Iterative e^x for x in [0,1): Horner evaluation of a truncated Taylor series on one multiplier.
// Define EXP_ROUND_EN to round each Horner product half-up instead of truncating.
module exponential
    import exp_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int FRAC_W  = EXP_FRAC_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FRAC_W-1:0] x_in,
    output logic              done,
    output logic [FRAC_W+1:0] result
);

    localparam int RES_W  = FRAC_W + 2;
    localparam int PROD_W = RES_W + FRAC_W;

    exp_state_e          state_q, state_d;
    logic [RES_W-1:0]    acc_q, acc_d;
    logic [FRAC_W-1:0]   x_q, x_d;
    logic [EXP_K_W-1:0]  k_q, k_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                done_q, done_d;

    logic [EXP_K_W-1:0]  rom_idx;
    logic [RES_W-1:0]    coeff;
    logic [PROD_W-1:0]   prod;

    // Drop the low FRAC_W bits of acc*x, optionally rounding half-up first.
    function automatic logic [RES_W-1:0] scale_prod(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] t;
`ifdef EXP_ROUND_EN
        t = p + (PROD_W'(1) << (FRAC_W - 1));
`else
        t = p;
`endif
        return t[FRAC_W +: RES_W];
    endfunction

    // In IDLE the ROM presents the seed coefficient c_(N_TERMS-1).
    assign rom_idx = (state_q == CALC) ? k_q : EXP_K_W'(N_TERMS - 1);

    exp_coeff_rom #(
        .FRAC_W (FRAC_W)
    ) u_rom (
        .k_i     (rom_idx),
        .coeff_o (coeff)
    );

    assign prod = PROD_W'(acc_q) * PROD_W'(x_q);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        x_d      = x_q;
        k_d      = k_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    acc_d   = coeff;
                    k_d     = EXP_K_W'(N_TERMS - 2);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = scale_prod(prod) + coeff;
                if (k_q == '0) begin
                    result_d = acc_d;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    k_d = k_q - EXP_K_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_exponential.sv
// Scoreboard bench for exponential: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_exponential;

    localparam int N_TERMS = 8;
    localparam int LAT     = N_TERMS - 1;

    // Hand-evaluated Horner chains (c7=13,c6=91,c5=546,c4=2731,c3=10923,c2=32768,c1=c0=65536).
`ifdef EXP_ROUND_EN
    localparam logic [17:0] E_HALF = 18'h1A613;
    localparam logic [17:0] E_QTR  = 18'h148B6;
    localparam logic [17:0] E_ONE  = 18'h2B7DD;
`else
    localparam logic [17:0] E_HALF = 18'h1A612;
    localparam logic [17:0] E_QTR  = 18'h148B5;
    localparam logic [17:0] E_ONE  = 18'h2B7D8;
`endif
    localparam logic [17:0] E_ZERO = 18'h10000;

    typedef struct {
        logic [17:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x_in;
    logic        done;
    logic [17:0] result;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    logic prev_done = 1'b0;

    exponential #(
        .N_TERMS (N_TERMS),
        .FRAC_W  (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x_in   (x_in),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            checks++;
            if (prev_done) begin
                failures++;
                $display("FAIL done_width: done high two cycles running at cyc %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: result=%h at cyc %0d, nothing outstanding", result, cyc);
            end else begin
                e = sb.pop_front();
                if (result !== e.res) begin
                    failures++;
                    $display("FAIL %s_result: got %h expected %h", e.name, result, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s_latency: done at cyc %0d expected %0d", e.name, cyc, e.cyc);
                end
                if (e.res[17]) begin
                    checks++;
                    if (result[17:16] !== 2'b10) begin
                        failures++;
                        $display("FAIL %s_int_field: got %b expected 10", e.name, result[17:16]);
                    end
                end
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push(input logic [17:0] res, input string name);
        exp_t e;
        e.res  = res;
        e.cyc  = cyc + LAT;
        e.name = name;
        sb.push_back(e);
    endtask

    // Raise start at a negedge, let one posedge accept, then record the expectation.
    task automatic issue(input logic [15:0] x, input logic [17:0] res, input string name);
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        @(posedge clk);
        #1;
        push(res, name);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d results still outstanding after %0d cycles", name, sb.size(), n);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        x_in  = 16'h0000;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_done", {17'd0, done}, 18'd0);
            chk("reset_result", result, 18'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_done", {17'd0, done}, 18'd0);
            chk("idle_result", result, 18'd0);
        end

        issue(16'h8000, E_HALF, "x_half");
        drain("x_half");
        issue(16'h0000, E_ZERO, "x_zero");
        drain("x_zero");
        issue(16'h4000, E_QTR, "x_quarter");
        drain("x_quarter");
        issue(16'hFFFF, E_ONE, "x_max");
        drain("x_max");

        // start pulses and operand changes while CALC runs must not disturb the result.
        issue(16'h4000, E_QTR, "ignore");
        @(negedge clk);
        x_in  = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        x_in  = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        drain("ignore");
        @(negedge clk);
        chk("ignore_hold", result, E_QTR);

        // Level start: the second accept lands on the edge right after done.
        @(negedge clk);
        start = 1'b1;
        x_in  = 16'h8000;
        @(posedge clk);
        #1;
        push(E_HALF, "b2b_first");
        x_in = 16'h0000;
        repeat (LAT + 1) @(posedge clk);
        #1;
        push(E_ZERO, "b2b_second");
        start = 1'b0;
        drain("b2b");

        // Abort mid-CALC: after the reset edge outputs are zero and no done follows.
        issue(16'hFFFF, E_ONE, "abort");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        d0 = n_done;
        chk("abort_result", result, 18'd0);
        chk("abort_done", {17'd0, done}, 18'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (n_done != d0) begin
            failures++;
            $display("FAIL abort_no_done: saw %0d done pulses expected 0", n_done - d0);
        end
        chk("abort_result_hold", result, 18'd0);

        issue(16'h8000, E_HALF, "after_abort");
        drain("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
